// File: rtl/sram_pkg.sv
// Shared constants and helpers for the 1R1W pipelined SRAM.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: legal read-latency bounds, byte-lane width, mask-width helper.
package sram_pkg;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;
    localparam int BYTE_WIDTH       = 8;

    // One write-enable bit per byte lane.
    function automatic int calc_mask_width(input int data_width);
        return data_width / BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/sram_1r1w_pipe_if.sv
// Bus bundle for sram_1r1w_pipe: write port, read request and read response.
// Latency: n/a (wires only). Backpressure: valid/ready on request and response.
// Modports: master = memory client, slave = memory. Optional macro:
// SRAM_1R1W_PIPE_PARITY_EN adds r_resp_perr (one parity-error bit per byte).
interface sram_1r1w_pipe_if #(
    parameter int data_width = 32,
    parameter int addr_width = 8
);
    import sram_pkg::*;

    localparam int mask_width = calc_mask_width(data_width);

    logic                  w_en;
    logic [addr_width-1:0] w_addr;
    logic [data_width-1:0] w_data;
    logic [mask_width-1:0] w_mask;

    logic                  r_req_valid;
    logic                  r_req_ready;
    logic [addr_width-1:0] r_req_addr;

    logic                  r_resp_valid;
    logic                  r_resp_ready;
    logic [data_width-1:0] r_resp_data;
`ifdef SRAM_1R1W_PIPE_PARITY_EN
    logic [mask_width-1:0] r_resp_perr;
`endif

    modport master (
`ifdef SRAM_1R1W_PIPE_PARITY_EN
        input  r_resp_perr,
`endif
        output w_en, w_addr, w_data, w_mask,
        output r_req_valid, r_req_addr, r_resp_ready,
        input  r_req_ready, r_resp_valid, r_resp_data
    );

    modport slave (
`ifdef SRAM_1R1W_PIPE_PARITY_EN
        output r_resp_perr,
`endif
        input  w_en, w_addr, w_data, w_mask,
        input  r_req_valid, r_req_addr, r_resp_ready,
        output r_req_ready, r_resp_valid, r_resp_data
    );

endinterface

// File: rtl/sram_resp_fifo.sv
// Generic synchronous FIFO, valid/ready on both sides, fall-through when empty.
// Latency: 0 cycles when empty (input appears on output combinationally), else head.
// Backpressure: in_ready = !full (registered state only); head held until out_ready.
// Ports: clk, rst_n (async active-low), in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module sram_resp_fifo #(
    parameter int width = 32,
    parameter int depth = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data
);

    localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;
    localparam int cnt_w = $clog2(depth + 1);

    logic [width-1:0] store [depth];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [cnt_w-1:0] count;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(depth - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == cnt_w'(depth));
    assign in_ready  = !full;
    assign out_valid = !empty || in_valid;
    assign out_data  = empty ? in_data : store[rd_ptr];
    // An entry that falls straight through to a ready consumer is never stored.
    assign push      = in_valid && !full && !(empty && out_ready);
    assign pop       = !empty && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + cnt_w'(1);
            end else if (!push && pop) begin
                count <= count - cnt_w'(1);
            end
        end
    end

endmodule

// File: rtl/sram_1r1w_pipe.sv
// Simple dual-port SRAM (1 write, 1 read) with byte mask and pipelined, credit-limited reads.
// Latency: read_latency (1 or 2) cycles from accept to r_resp_valid when the buffer is empty.
// Backpressure: r_req_ready drops once resp_depth reads are outstanding; responses wait in a FIFO.
// Ports: clock, resetn (async active-low), bus (slave modport: write, read request, read response).
// Optional macro SRAM_1R1W_PIPE_PARITY_EN: per-byte even parity stored, r_resp_perr reported.
module sram_1r1w_pipe
    import sram_pkg::*;
#(
    parameter int data_width   = 32,
    parameter int addr_width   = 8,
    parameter int read_latency = 1,
    parameter int resp_depth   = read_latency + 1
) (
    input  logic             clock,
    input  logic             resetn,
    sram_1r1w_pipe_if.slave  bus
);

    localparam int mask_width = calc_mask_width(data_width);
    localparam int depth      = 1 << addr_width;
    localparam int cnt_w      = $clog2(resp_depth + 1);
`ifdef SRAM_1R1W_PIPE_PARITY_EN
    localparam int entry_w    = data_width + mask_width;
`else
    localparam int entry_w    = data_width;
`endif

    if (read_latency < READ_LATENCY_MIN || read_latency > READ_LATENCY_MAX) begin : g_bad_latency
        $error("sram_1r1w_pipe: read_latency must be 1 or 2");
    end
    if (data_width < BYTE_WIDTH || (data_width % BYTE_WIDTH) != 0) begin : g_bad_width
        $error("sram_1r1w_pipe: data_width must be a non-zero multiple of 8");
    end

    logic [data_width-1:0] mem [depth];
`ifdef SRAM_1R1W_PIPE_PARITY_EN
    logic [mask_width-1:0] par_mem [depth];
    logic [mask_width-1:0] rd_perr;
`endif

    logic [data_width-1:0] rd_data;
    logic [entry_w-1:0]    rd_entry;
    logic [cnt_w-1:0]      outstanding;
    logic                  ready_en;
    logic                  accept;
    logic                  handoff;
    logic                  s1_valid;
    logic [entry_w-1:0]    s1_entry;
    logic                  pipe_valid;
    logic [entry_w-1:0]    pipe_entry;
    logic                  fifo_in_ready;
    logic [entry_w-1:0]    fifo_out;

    // Writes are gated by resetn so a write presented during reset is dropped.
    always_ff @(posedge clock) begin
        for (int i = 0; i < mask_width; i++) begin
            if (resetn && bus.w_en && bus.w_mask[i]) begin
                mem[bus.w_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.w_data[i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef SRAM_1R1W_PIPE_PARITY_EN
                par_mem[bus.w_addr][i] <= ^bus.w_data[i*BYTE_WIDTH +: BYTE_WIDTH];
`endif
            end
        end
    end

    // Write-first merge: bytes being written to the read address this cycle bypass the array.
    always_comb begin
        rd_data = mem[bus.r_req_addr];
`ifdef SRAM_1R1W_PIPE_PARITY_EN
        rd_perr = '0;
`endif
        for (int i = 0; i < mask_width; i++) begin
            if (bus.w_en && bus.w_mask[i] && (bus.w_addr == bus.r_req_addr)) begin
                rd_data[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.w_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
`ifdef SRAM_1R1W_PIPE_PARITY_EN
            else begin
                rd_perr[i] = ^{mem[bus.r_req_addr][i*BYTE_WIDTH +: BYTE_WIDTH],
                               par_mem[bus.r_req_addr][i]};
            end
`endif
        end
    end

`ifdef SRAM_1R1W_PIPE_PARITY_EN
    assign rd_entry = {rd_perr, rd_data};
`else
    assign rd_entry = rd_data;
`endif

    // ready_en keeps r_req_ready low until the first clock after reset release.
    assign bus.r_req_ready = ready_en && (outstanding < cnt_w'(resp_depth));
    assign accept          = bus.r_req_valid && bus.r_req_ready;
    assign handoff         = bus.r_resp_valid && bus.r_resp_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ready_en    <= 1'b0;
            outstanding <= '0;
        end else begin
            ready_en <= 1'b1;
            if (accept && !handoff) begin
                outstanding <= outstanding + cnt_w'(1);
            end else if (!accept && handoff) begin
                outstanding <= outstanding - cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_entry <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_entry <= rd_entry;
            end
        end
    end

    if (read_latency == 2) begin : g_lat2
        logic               s2_valid;
        logic [entry_w-1:0] s2_entry;

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                s2_valid <= 1'b0;
                s2_entry <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_entry <= s1_entry;
                end
            end
        end

        assign pipe_valid = s2_valid;
        assign pipe_entry = s2_entry;
    end else begin : g_lat1
        assign pipe_valid = s1_valid;
        assign pipe_entry = s1_entry;
    end

    sram_resp_fifo #(
        .width (entry_w),
        .depth (resp_depth)
    ) u_resp_fifo (
        .clk       (clock),
        .rst_n     (resetn),
        .in_valid  (pipe_valid),
        .in_ready  (fifo_in_ready),
        .in_data   (pipe_entry),
        .out_valid (bus.r_resp_valid),
        .out_ready (bus.r_resp_ready),
        .out_data  (fifo_out)
    );

`ifdef SRAM_1R1W_PIPE_PARITY_EN
    assign {bus.r_resp_perr, bus.r_resp_data} = fifo_out;
`else
    assign bus.r_resp_data = fifo_out;
`endif

    // The outstanding-read credit must make a push into a full buffer impossible.
    assert property (@(posedge clock) disable iff (!resetn) !(pipe_valid && !fifo_in_ready));

endmodule
